// File: rtl/bcd_to_bin_converter.sv
// Sequential 4-digit BCD to binary converter using reverse double-dabble (shift right, subtract 3).
// Optional build macro BCD2BIN_SATURATE_EN clamps value to all ones on overflow.
module bcd_to_bin_converter #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       dig_thou,
  input  logic [3:0]       dig_hund,
  input  logic [3:0]       dig_tens,
  input  logic [3:0]       dig_unit,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] value,
  output logic             overflow,
  output logic             err_digit,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only while busy=0; done pulses for exactly
  // one cycle (the DONE state) and value/overflow/err_digit change only then.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic [3:0]  cnt;
  logic        err_pend;

  logic [15:0] bcd_sh;
  logic [15:0] bcd_next;
  logic [13:0] bin_next;
  logic        ovf_next;
  logic [OUT_W-1:0] val_next;
  logic        bad_digit;

  always_comb begin
    bcd_sh   = {1'b0, bcd[15:1]};
    bin_next = {bcd[0], bin[13:1]};
    bcd_next = bcd_sh;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sh[4*i+3]) begin
        bcd_next[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end
    ovf_next = ((bin_next >> OUT_W) != 14'd0);
`ifdef BCD2BIN_SATURATE_EN
    val_next = ovf_next ? {OUT_W{1'b1}} : bin_next[OUT_W-1:0];
`else
    val_next = bin_next[OUT_W-1:0];
`endif
    bad_digit = (dig_thou > 4'd9) || (dig_hund > 4'd9) ||
                (dig_tens > 4'd9) || (dig_unit > 4'd9);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
      err_pend  <= 1'b0;
      value     <= '0;
      overflow  <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd      <= {dig_thou, dig_hund, dig_tens, dig_unit};
            bin      <= '0;
            cnt      <= '0;
            err_pend <= bad_digit;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // A bad digit spends one SHIFT cycle as its pending-error slot so
          // that done lands one edge after acceptance.
          if (err_pend) begin
            err_pend  <= 1'b0;
            value     <= '0;
            overflow  <= 1'b0;
            err_digit <= 1'b1;
            state     <= DONE;
          end else begin
            bcd <= bcd_next;
            bin <= bin_next;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd13) begin
              value     <= val_next;
              overflow  <= ovf_next;
              err_digit <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Randomized and directed bench for bcd_to_bin_converter against an arithmetic decimal model.
// Honours BCD2BIN_SATURATE_EN when computing expected values.
module tb_bcd_to_bin_converter;

  localparam int OUT_W = 12;
  localparam int EW    = OUT_W + 2;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [3:0]       dig_thou, dig_hund, dig_tens, dig_unit;
  logic             busy, done, overflow, err_digit;
  logic [OUT_W-1:0] value;
  logic [1:0]       state_dbg;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  bcd_to_bin_converter #(.OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dig_thou(dig_thou), .dig_hund(dig_hund), .dig_tens(dig_tens), .dig_unit(dig_unit),
    .busy(busy), .done(done), .value(value), .overflow(overflow),
    .err_digit(err_digit), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {err, overflow, value} from decimal arithmetic.
  function automatic logic [EW-1:0] model(input int th, input int h, input int t, input int u);
    int v;
    logic ovf;
    logic [OUT_W-1:0] val;
    if (th > 9 || h > 9 || t > 9 || u > 9) return {1'b1, 1'b0, {OUT_W{1'b0}}};
    v   = th * 1000 + h * 100 + t * 10 + u;
    ovf = (v >= (1 << OUT_W));
`ifdef BCD2BIN_SATURATE_EN
    val = ovf ? {OUT_W{1'b1}} : OUT_W'(v);
`else
    val = OUT_W'(v);
`endif
    return {1'b0, ovf, val};
  endfunction

  task automatic set_digits(input int th, input int h, input int t, input int u);
    dig_thou = 4'(th); dig_hund = 4'(h); dig_tens = 4'(t); dig_unit = 4'(u);
  endtask

  task automatic run_conv(input int th, input int h, input int t, input int u);
    logic [EW-1:0] e;
    int lat;
    int exp_lat;
    exp_q.push_back(model(th, h, t, u));
    exp_lat = (th > 9 || h > 9 || t > 9 || u > 9) ? 1 : 14;
    @(negedge clk);
    set_digits(th, h, t, u);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL latency %0d%0d%0d%0d: got %0d want %0d", th, h, t, u, lat, exp_lat); end
    checks++;
    if (value !== e[OUT_W-1:0]) begin errors++; $display("FAIL value %0d%0d%0d%0d: got %h want %h", th, h, t, u, value, e[OUT_W-1:0]); end
    checks++;
    if (overflow !== e[OUT_W]) begin errors++; $display("FAIL overflow %0d%0d%0d%0d: got %b want %b", th, h, t, u, overflow, e[OUT_W]); end
    checks++;
    if (err_digit !== e[OUT_W+1]) begin errors++; $display("FAIL err_digit %0d%0d%0d%0d: got %b want %b", th, h, t, u, err_digit, e[OUT_W+1]); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL end_of_done: done=%b busy=%b want 0 0", done, busy); end
    checks++;
    if (value !== e[OUT_W-1:0]) begin errors++; $display("FAIL value_hold: got %h want %h", value, e[OUT_W-1:0]); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    set_digits(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, value, overflow, err_digit, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b value=%h ovf=%b err=%b st=%0d want all 0",
               busy, done, value, overflow, err_digit, state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_conv(1, 2, 3, 4);
    run_conv(4, 0, 9, 5);
    run_conv(4, 0, 9, 6);
    run_conv(9, 9, 9, 9);
    run_conv(0, 0, 0, 0);
    run_conv(1, 10, 0, 0);
    run_conv(0, 0, 0, 15);
  endtask

  task automatic test_ignore_start();
    logic [EW-1:0] e;
    int lat;
    e = model(1, 2, 3, 4);
    @(negedge clk);
    set_digits(1, 2, 3, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
      start = (lat == 5);
      if (lat == 5) set_digits(9, 9, 9, 9);
    end
    start = 1'b1;
    set_digits(5, 5, 5, 5);
    checks++;
    if (lat !== 14) begin errors++; $display("FAIL ignore_latency: got %0d want 14", lat); end
    checks++;
    if (value !== e[OUT_W-1:0]) begin errors++; $display("FAIL ignore_value: got %h want %h", value, e[OUT_W-1:0]); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_in_done: busy=%b done=%b want 0 0", busy, done); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int sets[3][4];
    logic [EW-1:0] e;
    int n, edge_n, last_done;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) sets[i][j] = $urandom_range(0, 9);
    for (int i = 0; i < 3; i++) exp_q.push_back(model(sets[i][0], sets[i][1], sets[i][2], sets[i][3]));
    @(negedge clk);
    set_digits(sets[0][0], sets[0][1], sets[0][2], sets[0][3]);
    start = 1'b1;
    n = 0; edge_n = 0; last_done = 0;
    while (n < 3 && edge_n < 100) begin
      @(posedge clk); #1; edge_n++;
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (value !== e[OUT_W-1:0] || overflow !== e[OUT_W]) begin
          errors++;
          $display("FAIL b2b_value[%0d]: got %h/%b want %h/%b", n, value, overflow, e[OUT_W-1:0], e[OUT_W]);
        end
        checks++;
        if ((n == 0 && edge_n != 15) || (n > 0 && edge_n - last_done != 16)) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: edge %0d prev %0d", n, edge_n, last_done);
        end
        last_done = edge_n;
        n++;
        if (n < 3) set_digits(sets[n][0], sets[n][1], sets[n][2], sets[n][3]);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_timeout: got %0d conversions want 3", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clk);
    set_digits(1, 2, 3, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, value, overflow, err_digit} !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b value=%h ovf=%b err=%b want all 0", busy, done, value, overflow, err_digit);
    end
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_done: got %0d pulses want 0", seen); end
    run_conv(0, 0, 4, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0)
        run_conv($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(10, 15));
      else
        run_conv($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
